// File: rtl/jtframe_mailbox_pkg.sv
// Shared constants for the host/MCU mailbox: default widths and ovf bit positions.
package jtframe_mailbox_pkg;

  localparam int DW_DEF  = 8;
  localparam int AW_DEF  = 2;

  // Bit positions inside the two-bit sticky overflow vector
  localparam int OVF_H2M = 0;
  localparam int OVF_M2H = 1;

  // Number of entries held by one direction for a given address width
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/jtframe_mailbox_fifo.sv
// One direction of the mailbox: first-word-fall-through FIFO with a separate
// occupancy counter. Optional sticky overflow flag under JTFRAME_MAILBOX_OVF_EN.
module jtframe_mailbox_fifo
  import jtframe_mailbox_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   cnt,
  output logic          full,
`ifdef JTFRAME_MAILBOX_OVF_EN
  output logic          ovf,
`endif
  output logic          empty
);

  localparam int DEPTH = depth_of(AW);
  // AW=0 still needs a one-bit pointer; it simply never leaves zero
  localparam int PW = (AW > 0) ? AW : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_reg [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [AW:0]   cnt_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_reg == FULL_CNT);
  assign empty   = (cnt_reg == '0);
  assign cnt     = cnt_reg;
  assign dout    = mem_reg[rd_ptr_reg];
  // A push into a full FIFO only goes through when a pop frees a slot this cycle
  assign do_push = push & (~full | pop);
  // A pop on an empty FIFO is ignored, even if a push lands in the same cycle
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; flush has priority over any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (clr) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Storage words; a flush keeps their contents, only reset zeroes them
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          mem_reg[gi] <= '0;
        else if (!clr && do_push && wr_ptr_reg == PW'(gi))
          mem_reg[gi] <= din;
      end
    end
  endgenerate

`ifdef JTFRAME_MAILBOX_OVF_EN
  logic ovf_reg;

  // Sticky record of a push dropped because the FIFO was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if (clr)
      ovf_reg <= 1'b0;
    else if (push && full && !pop)
      ovf_reg <= 1'b1;
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: rtl/jtframe_mailbox.sv
// Bidirectional host <-> MCU mailbox built from two independent FIFOs that
// share only the host flush. Define JTFRAME_MAILBOX_OVF_EN to add the ovf port.
module jtframe_mailbox
  import jtframe_mailbox_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h_wr,
  input  logic [DW-1:0] h_din,
  input  logic          h_rd,
  output logic [DW-1:0] h_dout,
  input  logic          h_clr,
  input  logic          m_wr,
  input  logic [DW-1:0] m_din,
  input  logic          m_rd,
  output logic [DW-1:0] m_dout,
  output logic          mcu_irq,
  output logic          host_stn,
  output logic          h2m_full,
  output logic          m2h_full,
  output logic [AW:0]   h2m_cnt,
`ifdef JTFRAME_MAILBOX_OVF_EN
  output logic [1:0]    ovf,
`endif
  output logic [AW:0]   m2h_cnt
);

  logic h2m_empty;
  logic m2h_empty;

`ifdef JTFRAME_MAILBOX_OVF_EN
  logic h2m_ovf;
  logic m2h_ovf;

  assign ovf[OVF_H2M] = h2m_ovf;
  assign ovf[OVF_M2H] = m2h_ovf;
`endif

  // Host writes, MCU reads
  jtframe_mailbox_fifo #(.DW(DW), .AW(AW)) u_h2m (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (h_wr),
    .pop   (m_rd),
    .clr   (h_clr),
    .din   (h_din),
    .dout  (m_dout),
    .cnt   (h2m_cnt),
    .full  (h2m_full),
`ifdef JTFRAME_MAILBOX_OVF_EN
    .ovf   (h2m_ovf),
`endif
    .empty (h2m_empty)
  );

  // MCU writes, host reads
  jtframe_mailbox_fifo #(.DW(DW), .AW(AW)) u_m2h (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (m_wr),
    .pop   (h_rd),
    .clr   (h_clr),
    .din   (m_din),
    .dout  (h_dout),
    .cnt   (m2h_cnt),
    .full  (m2h_full),
`ifdef JTFRAME_MAILBOX_OVF_EN
    .ovf   (m2h_ovf),
`endif
    .empty (m2h_empty)
  );

  assign mcu_irq  = ~h2m_empty;
  assign host_stn = m2h_empty;

endmodule

// File: tb/tb_jtframe_mailbox.sv
// Self-checking bench for jtframe_mailbox (DW=8, AW=2): vector table for the
// directed scenarios, hand sequences for flush/reset, random traffic vs a queue model.
module tb_jtframe_mailbox;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          h_wr = 1'b0, h_rd = 1'b0, h_clr = 1'b0;
  logic          m_wr = 1'b0, m_rd = 1'b0;
  logic [DW-1:0] h_din = '0, m_din = '0;
  logic [DW-1:0] h_dout, m_dout;
  logic          mcu_irq, host_stn, h2m_full, m2h_full;
  logic [AW:0]   h2m_cnt, m2h_cnt;
`ifdef JTFRAME_MAILBOX_OVF_EN
  logic [1:0]    ovf;
`endif

  jtframe_mailbox #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .h_wr     (h_wr),
    .h_din    (h_din),
    .h_rd     (h_rd),
    .h_dout   (h_dout),
    .h_clr    (h_clr),
    .m_wr     (m_wr),
    .m_din    (m_din),
    .m_rd     (m_rd),
    .m_dout   (m_dout),
    .mcu_irq  (mcu_irq),
    .host_stn (host_stn),
    .h2m_full (h2m_full),
    .m2h_full (m2h_full),
    .h2m_cnt  (h2m_cnt),
`ifdef JTFRAME_MAILBOX_OVF_EN
    .ovf      (ovf),
`endif
    .m2h_cnt  (m2h_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every output against expectations; flags follow from the counts
  task automatic chk_all(input string tag, input int e_h2m, input int e_m2h,
                         input bit chk_md, input logic [7:0] e_md,
                         input bit chk_hd, input logic [7:0] e_hd,
                         input logic [1:0] e_ovf);
    chk({tag, ".h2m_cnt"},  32'(h2m_cnt),  32'(e_h2m));
    chk({tag, ".m2h_cnt"},  32'(m2h_cnt),  32'(e_m2h));
    chk({tag, ".h2m_full"}, 32'(h2m_full), 32'(e_h2m == DEPTH));
    chk({tag, ".m2h_full"}, 32'(m2h_full), 32'(e_m2h == DEPTH));
    chk({tag, ".mcu_irq"},  32'(mcu_irq),  32'(e_h2m != 0));
    chk({tag, ".host_stn"}, 32'(host_stn), 32'(e_m2h == 0));
    if (chk_md) chk({tag, ".m_dout"}, 32'(m_dout), 32'(e_md));
    if (chk_hd) chk({tag, ".h_dout"}, 32'(h_dout), 32'(e_hd));
`ifdef JTFRAME_MAILBOX_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(e_ovf));
`else
    if (e_ovf > 2'd3) $display("unexpected ovf expectation");
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    h_wr = 0; h_rd = 0; h_clr = 0; m_wr = 0; m_rd = 0;
  endtask

  typedef struct {
    logic       h_wr;
    logic [7:0] h_din;
    logic       h_rd;
    logic       m_wr;
    logic [7:0] m_din;
    logic       m_rd;
    int         e_h2m;
    int         e_m2h;
    logic       cm;
    logic [7:0] e_md;
    logic       ch;
    logic [7:0] e_hd;
    logic [1:0] e_ovf;
  } vec_t;

  vec_t vecs [22];

  // Behavioural reference: each direction is just an ordered list of words
  logic [7:0] q_h2m [$];
  logic [7:0] q_m2h [$];
  logic [1:0] m_ovf;

  task automatic model_dir(inout logic [7:0] q [$], input logic push, input logic pop,
                           input logic [7:0] d, inout logic ovf_bit);
    bit popped;
    popped = pop && (q.size() > 0);
    if (popped) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovf_bit = 1'b1;
    end
  endtask

  initial begin
    // Directed vectors, applied from right after reset
    vecs[0]  = '{1,8'h5A,0, 0,8'h00,0, 1,0, 1,8'h5A, 0,8'h00, 2'b00};
    vecs[1]  = '{0,8'h00,0, 0,8'h00,1, 0,0, 0,8'h00, 0,8'h00, 2'b00};
    vecs[2]  = '{0,8'h00,0, 1,8'h01,0, 0,1, 0,8'h00, 1,8'h01, 2'b00};
    vecs[3]  = '{0,8'h00,0, 1,8'h02,0, 0,2, 0,8'h00, 1,8'h01, 2'b00};
    vecs[4]  = '{0,8'h00,0, 1,8'h03,0, 0,3, 0,8'h00, 1,8'h01, 2'b00};
    vecs[5]  = '{0,8'h00,0, 1,8'h04,0, 0,4, 0,8'h00, 1,8'h01, 2'b00};
    vecs[6]  = '{0,8'h00,0, 1,8'h05,0, 0,4, 0,8'h00, 1,8'h01, 2'b10};
    vecs[7]  = '{0,8'h00,1, 0,8'h00,0, 0,3, 0,8'h00, 1,8'h02, 2'b10};
    vecs[8]  = '{0,8'h00,1, 0,8'h00,0, 0,2, 0,8'h00, 1,8'h03, 2'b10};
    vecs[9]  = '{0,8'h00,1, 0,8'h00,0, 0,1, 0,8'h00, 1,8'h04, 2'b10};
    vecs[10] = '{0,8'h00,1, 0,8'h00,0, 0,0, 0,8'h00, 0,8'h00, 2'b10};
    vecs[11] = '{1,8'h10,0, 0,8'h00,0, 1,0, 1,8'h10, 0,8'h00, 2'b10};
    vecs[12] = '{1,8'h11,0, 0,8'h00,0, 2,0, 1,8'h10, 0,8'h00, 2'b10};
    vecs[13] = '{1,8'h12,0, 0,8'h00,0, 3,0, 1,8'h10, 0,8'h00, 2'b10};
    vecs[14] = '{1,8'h13,0, 0,8'h00,0, 4,0, 1,8'h10, 0,8'h00, 2'b10};
    vecs[15] = '{1,8'hAA,0, 0,8'h00,1, 4,0, 1,8'h11, 0,8'h00, 2'b10};
    vecs[16] = '{0,8'h00,0, 0,8'h00,1, 3,0, 1,8'h12, 0,8'h00, 2'b10};
    vecs[17] = '{0,8'h00,0, 0,8'h00,1, 2,0, 1,8'h13, 0,8'h00, 2'b10};
    vecs[18] = '{0,8'h00,0, 0,8'h00,1, 1,0, 1,8'hAA, 0,8'h00, 2'b10};
    vecs[19] = '{0,8'h00,0, 0,8'h00,1, 0,0, 0,8'h00, 0,8'h00, 2'b10};
    vecs[20] = '{0,8'h00,1, 1,8'h33,0, 0,1, 0,8'h00, 1,8'h33, 2'b10};
    vecs[21] = '{0,8'h00,1, 0,8'h00,0, 0,0, 0,8'h00, 0,8'h00, 2'b10};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 1, 8'h00, 1, 8'h00, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 22; i++) begin
      h_wr = vecs[i].h_wr; h_din = vecs[i].h_din; h_rd = vecs[i].h_rd;
      m_wr = vecs[i].m_wr; m_din = vecs[i].m_din; m_rd = vecs[i].m_rd;
      step();
      $display("vec %0d: h_wr=%0b h_din=%02h h_rd=%0b m_wr=%0b m_din=%02h m_rd=%0b -> h2m_cnt=%0d m2h_cnt=%0d",
               i, h_wr, h_din, h_rd, m_wr, m_din, m_rd, h2m_cnt, m2h_cnt);
      chk_all($sformatf("vec%0d", i), vecs[i].e_h2m, vecs[i].e_m2h,
              vecs[i].cm, vecs[i].e_md, vecs[i].ch, vecs[i].e_hd, vecs[i].e_ovf);
    end
    idle_inputs();

    // Flush with a same-cycle push: three words queued each way first
    for (int i = 0; i < 3; i++) begin
      h_wr = 1; h_din = 8'(8'h21 + i); m_wr = 1; m_din = 8'(8'h41 + i);
      step();
      $display("clr-fill %0d: h2m_cnt=%0d m2h_cnt=%0d", i, h2m_cnt, m2h_cnt);
    end
    chk_all("clr_pre", 3, 3, 1, 8'h21, 1, 8'h41, 2'b10);
    h_clr = 1; h_wr = 1; h_din = 8'hEE; m_wr = 1; h_rd = 1; m_rd = 1;
    step();
    $display("clr: h2m_cnt=%0d m2h_cnt=%0d irq=%0b stn=%0b", h2m_cnt, m2h_cnt, mcu_irq, host_stn);
    chk_all("clr", 0, 0, 0, 8'h00, 0, 8'h00, 2'b00);
    idle_inputs();
    h_wr = 1; h_din = 8'h77;
    step();
    $display("post-clr push: h2m_cnt=%0d m_dout=%02h", h2m_cnt, m_dout);
    chk_all("post_clr", 1, 0, 1, 8'h77, 0, 8'h00, 2'b00);
    idle_inputs();

    // Random traffic against the queue model, starting from a flushed state
    h_clr = 1;
    step();
    h_clr = 0;
    q_h2m.delete(); q_m2h.delete(); m_ovf = 2'b00;
    for (int n = 0; n < 200; n++) begin
      logic [1:0] o;
      h_wr  = 1'($urandom_range(0, 1));
      h_rd  = 1'($urandom_range(0, 2) == 0);
      m_wr  = 1'($urandom_range(0, 1));
      m_rd  = 1'($urandom_range(0, 2) == 0);
      h_clr = 1'($urandom_range(0, 31) == 0);
      h_din = 8'($urandom);
      m_din = 8'($urandom);
      if (h_clr) begin
        q_h2m.delete(); q_m2h.delete(); m_ovf = 2'b00;
      end else begin
        o = m_ovf;
        model_dir(q_h2m, h_wr, m_rd, h_din, o[0]);
        model_dir(q_m2h, m_wr, h_rd, m_din, o[1]);
        m_ovf = o;
      end
      step();
      $display("rnd %0d: hw=%0b hr=%0b mw=%0b mr=%0b clr=%0b -> h2m_cnt=%0d m2h_cnt=%0d",
               n, h_wr, h_rd, m_wr, m_rd, h_clr, h2m_cnt, m2h_cnt);
      chk_all($sformatf("rnd%0d", n), q_h2m.size(), q_m2h.size(),
              q_h2m.size() > 0, (q_h2m.size() > 0) ? q_h2m[0] : 8'h00,
              q_m2h.size() > 0, (q_m2h.size() > 0) ? q_m2h[0] : 8'h00, m_ovf);
    end
    idle_inputs();

    // Asynchronous reset with two words queued each way
    h_clr = 1;
    step();
    h_clr = 0;
    for (int i = 0; i < 2; i++) begin
      h_wr = 1; h_din = 8'(8'h61 + i); m_wr = 1; m_din = 8'(8'h71 + i);
      step();
    end
    chk_all("rst_pre", 2, 2, 1, 8'h61, 1, 8'h71, 2'b00);
    h_din = 8'h99; m_din = 8'h98;
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: h2m_cnt=%0d m2h_cnt=%0d m_dout=%02h h_dout=%02h", h2m_cnt, m2h_cnt, m_dout, h_dout);
    chk_all("rst_async", 0, 0, 1, 8'h00, 1, 8'h00, 2'b00);
    step();
    chk_all("rst_hold", 0, 0, 1, 8'h00, 1, 8'h00, 2'b00);
    #2;
    rst_n = 1'b1;
    m_wr = 0;
    h_din = 8'h44;
    step();
    $display("post-reset push: h2m_cnt=%0d m_dout=%02h", h2m_cnt, m_dout);
    chk_all("rst_post", 1, 0, 1, 8'h44, 1, 8'h00, 2'b00);
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
